// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- sequential restoring divider, one quotient bit per clock.
//
// Optional feature macro: SIGNED_DIV_EN
//   defined   : adds input 'sign'; sign=1 divides two's-complement operands
//   undefined : unsigned division only, no 'sign' port
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request pulse, sampled only while idle
//   sign       in   (SIGNED_DIV_EN only) signed operation, captured with start
//   dataA      in   dividend, captured on an accepted start
//   dataB      in   divisor, captured on an accepted start
//   busy       out  high while computing and during the done cycle
//   done       out  one-cycle pulse, results valid
//   quotient   out  result quotient, held until the next done
//   remainder  out  result remainder, held until the next done
//   divZero    out  divisor was zero (set together with done)
//
// Timing: done rises WIDTH clocks after the accepting edge (a zero divisor
// skips the iteration phase and finishes on the accepting edge itself).
// ---------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SIGNED_DIV_EN
    input  logic             sign,
`endif
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] dvd_q;      // dividend, shifted out MSB first; quotient bits shift in
    logic [WIDTH-1:0] dvs_q;      // divisor (magnitude)
    logic             neg_q_q;    // negate quotient at the end
    logic             neg_r_q;    // negate remainder at the end
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             div_zero;
    logic             last_iter;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;

    assign accept    = (state_q == S_IDLE) && start;
    assign div_zero  = (dataB == '0);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Operand conditioning: the core always divides magnitudes.
`ifdef SIGNED_DIV_EN
    assign a_neg = sign & dataA[WIDTH-1];
    assign b_neg = sign & dataB[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign a_mag = a_neg ? (~dataA + 1'b1) : dataA;
    assign b_mag = b_neg ? (~dataB + 1'b1) : dataB;

    // One restoring step. The shifted remainder needs WIDTH+1 bits because
    // it can reach 2*divisor-1 before the trial subtraction.
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_nx, dvd_nx;

    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        fits    = (shifted >= {1'b0, dvs_q});
        rem_nx  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_nx  = {dvd_q[WIDTH-2:0], fits};
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = div_zero ? S_DONE : S_CALC;
            S_CALC: if (last_iter) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // ---------------- iteration datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
        end else if (state_q == S_CALC) begin
            cnt_q   <= cnt_q + CW'(1);
            rem_q   <= rem_nx;
            dvd_q   <= dvd_nx;
        end
    end

    // Result load happens only on the edge that enters DONE. The sign
    // fix-up is applied here so signed mode costs no extra cycle.
    always_comb begin
        quot_d = quot_q;
        remo_d = remo_q;
        dz_d   = dz_q;
        if (accept && div_zero) begin
            quot_d = '1;
            remo_d = dataA;
            dz_d   = 1'b1;
        end else if (state_q == S_CALC && last_iter) begin
            quot_d = neg_q_q ? (~dvd_nx + 1'b1) : dvd_nx;
            remo_d = neg_r_q ? (~rem_nx + 1'b1) : rem_nx;
            dz_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            remo_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            quot_q <= quot_d;
            remo_q <= remo_d;
            dz_q   <= dz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign divZero   = dz_q;

endmodule
